oam_dma_arbiter: RTL and testbench
==================================

Name: oam_dma_arbiter

Overview:
- Owns the CPU memory bus: sits between the cpu core's memory port and the downstream main memory bus, with a separate HRAM port.
- Implements the FF46 OAM DMA engine: copies 160 bytes from {src,8'h00} to FE00-FE9F, one byte per M-cycle.
- While DMA is active, the main bus belongs to DMA exclusively; the CPU may only reach HRAM (FF80-FFFE).

Parameters:
- T_PER_M, 4, clocks per M-cycle; must match cpu T-state count.
- DMA_LEN, 160, bytes per transfer.
- DMA_DST, 16'hFE00, destination base.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_cpu_rd_addr  in  16  CPU read address
- o_cpu_rd_data  out  8  read data returned to CPU
- i_cpu_wr_en  in  1  CPU write strobe
- i_cpu_wr_addr  in  16  CPU write address
- i_cpu_wr_data  in  8  CPU write data
- o_mem_rd_addr  out  16  main bus read address
- i_mem_rd_data  in  8  main bus read data; valid 1 clock after address
- o_mem_wr_en  out  1  main bus write strobe
- o_mem_wr_addr  out  16  main bus write address
- o_mem_wr_data  out  8  main bus write data
- o_hram_rd_addr  out  7  HRAM read index (addr[6:0])
- i_hram_rd_data  in  8  HRAM read data; 1-clock latency
- o_hram_wr_en  out  1  HRAM write strobe
- o_hram_wr_addr  out  7  HRAM write index
- o_hram_wr_data  out  8  HRAM write data
- o_dma_active  out  1  high from trigger until the last byte is written

Behaviour:
- Reset: state IDLE; src register 8'hFF; byte index 0; t-counter 0; o_dma_active 0; all write enables 0; read-select register = MAIN.
- Address decode: HRAM = FF80-FFFE. DMA register = FF46. Everything else is MAIN.
- Routing: HRAM accesses always go to the HRAM port. MAIN accesses go to the main bus except when DMA owns it. Outputs are combinational muxes.
- FF46 write: latches src and is absorbed (not forwarded to main bus). FF46 read returns src, muxed via the registered read-select.
- Read return: the read-select (HRAM/MAIN/FF46/BLOCKED) is registered each clock, matching the 1-clock read latency.
- CPU blocking: a CPU MAIN read while o_dma_active returns 8'hFF. A CPU MAIN write while o_dma_active is dropped.
- States:
  - IDLE: main bus follows the CPU. An FF46 write goes to START.
  - START: one M-cycle delay. o_dma_active=1 and the main bus is already locked. Then go to XFER with idx=0 and t=0.
  - XFER: per M-cycle with t counting 0..T_PER_M-1:
    - t=0: o_mem_rd_addr={src',idx}.
    - t=2: sample i_mem_rd_data into a byte register.
    - t=3: o_mem_wr_en=1 for one clock, addr=DMA_DST+idx.
    - At t=3, if idx==DMA_LEN-1, go to IDLE and deassert o_dma_active on the next clock. Otherwise idx+1.
- Source mapping: src' = src when src<=8'hDF; src' = src-8'h20 for E0-FF (echo mirror).
- Restart: an FF46 write during START or XFER reloads src, zeroes idx and re-enters START. Any partially read byte is discarded; the bus stays locked throughout.
- Simultaneous events: a CPU FF46 write in the same clock as the final DMA write. The final write completes, then the FSM goes to START, not IDLE.
- Reset mid-transfer: returns to IDLE in the same clock edge; no further main bus writes are issued.
- Total DMA duration from the clock after the trigger: (1+DMA_LEN)*T_PER_M clocks = 644 with defaults.

Optional Feature:
- Macro: OAM_DMA_STATUS_EN.
- When defined, adds two output ports:
  - o_dma_done (1): one-clock pulse on the clock o_dma_active falls; not pulsed on a restart.
  - o_dma_idx (8): current byte index, 0 when IDLE.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package oam_dma_pkg holds:
  - dma_state_t enum (IDLE, START, XFER)
  - rd_sel_t enum (MAIN, HRAM, REG, BLOCKED)
  - constants: DMA_REG_ADDR=16'hFF46, HRAM_LO=16'hFF80, HRAM_HI=16'hFFFE, DMA_SRC_MAX=8'hDF
- One sub-module: oam_dma_engine (FSM, counters, byte register). The top module keeps decode, muxing and CPU blocking.

Test Plan:
- Reset, then CPU reads FF46 -> 8'hFF. CPU writes C000=8'h5A -> main bus write C000/5A; o_hram_wr_en stays 0.
- Preload C000+i=i, write FF46=8'hC0 -> o_dma_active high for 644 clocks. FE00..FE9F receive 00..9F, one write per 4 clocks; the first write lands at clock 4*1+3 after the trigger.
- During DMA, CPU reads 0150 -> 8'hFF; CPU writes C123 -> no main bus write. CPU write/read FF90=8'h33 -> HRAM write, readback 33.
- Write FF46=8'hE1 -> reads are sourced from C100-C19F.
- Write FF46=8'hC0, then at idx=50 write FF46=8'hD0 -> idx restarts at 0 after a 4-clock delay. FE00-FE9F end holding the D000 data; total active time 50*4+4+644 clocks.
- Assert i_rst at idx=20 -> o_dma_active=0 next clock, no further FE-range writes, FF46 reads 8'hFF.

Source files
------------

// File: rtl/oam_dma_pkg.sv
// Shared state encodings, address map and decode helpers for the OAM DMA arbiter.
package oam_dma_pkg;

   typedef enum logic [1:0] {IDLE, START, XFER} dma_state_t;
   typedef enum logic [1:0] {MAIN, HRAM, REG, BLOCKED} rd_sel_t;

   localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
   localparam logic [15:0] HRAM_LO      = 16'hFF80;
   localparam logic [15:0] HRAM_HI      = 16'hFFFE;
   localparam logic [7:0]  DMA_SRC_MAX  = 8'hDF;

   function automatic logic is_hram(input logic [15:0] addr);
      return (addr >= HRAM_LO) && (addr <= HRAM_HI);
   endfunction

   // E0-FF sources fold onto the C0-DF echo mirror
   function automatic logic [7:0] map_src(input logic [7:0] src);
      return (src <= DMA_SRC_MAX) ? src : src - 8'h20;
   endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// OAM DMA engine: FSM, M-cycle/byte counters and the copy byte register.
// OAM_DMA_STATUS_EN adds the done pulse and byte index outputs.
module oam_dma_engine
   import oam_dma_pkg::*;
#(
   parameter int unsigned T_PER_M = 4,
   parameter int unsigned DMA_LEN = 160,
   parameter logic [15:0] DMA_DST = 16'hFE00
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_trig,
   input  logic [7:0]  i_trig_data,
   input  logic [7:0]  i_mem_rd_data,
   output logic        o_active,
   output logic [7:0]  o_src,
   output logic [15:0] o_rd_addr,
   output logic        o_wr_en,
   output logic [15:0] o_wr_addr,
   output logic [7:0]  o_wr_data
`ifdef OAM_DMA_STATUS_EN
  ,output logic        o_done,
   output logic [7:0]  o_idx
`endif
);

   localparam int unsigned TW = (T_PER_M > 1) ? $clog2(T_PER_M) : 1;

   dma_state_t    state_q, state_d;
   logic [TW-1:0] t_q;
   logic [7:0]    idx_q, src_q, byte_q;
   logic          last_t, last_byte;

   always_comb begin
      last_t    = (t_q == TW'(T_PER_M - 1));
      last_byte = (idx_q == 8'(DMA_LEN - 1));
      state_d   = state_q;
      unique case (state_q)
         IDLE:    if (i_trig) state_d = START;
         START:   if (i_trig) state_d = START;
                  else if (last_t) state_d = XFER;
         XFER:    if (i_trig) state_d = START;
                  else if (last_t && last_byte) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         src_q   <= 8'hFF;
         idx_q   <= '0;
         t_q     <= '0;
         byte_q  <= '0;
      end else begin
         state_q <= state_d;
         if (i_trig) src_q <= i_trig_data;
         if (i_trig || state_q == IDLE) begin
            t_q   <= '0;
            idx_q <= '0;
         end else begin
            t_q <= last_t ? '0 : t_q + TW'(1);
            if (state_q == XFER && last_t && !last_byte) idx_q <= idx_q + 8'd1;
            // read address is held across the M-cycle, so t=2 data is stable
            if (state_q == XFER && t_q == TW'(2)) byte_q <= i_mem_rd_data;
         end
      end
   end

   always_comb begin
      o_active  = (state_q != IDLE);
      o_src     = src_q;
      o_rd_addr = {map_src(src_q), idx_q};
      o_wr_en   = (state_q == XFER) && last_t;
      o_wr_addr = DMA_DST + {8'h00, idx_q};
      o_wr_data = byte_q;
   end

`ifdef OAM_DMA_STATUS_EN
   logic done_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) done_q <= 1'b0;
      else       done_q <= (state_q == XFER) && (state_d == IDLE);
   end

   always_comb begin
      o_done = done_q;
      o_idx  = (state_q == IDLE) ? 8'h00 : idx_q;
   end
`endif

endmodule

// File: rtl/oam_dma_arbiter.sv
// CPU memory bus owner: address decode, bus muxing, CPU blocking and the FF46 OAM DMA.
// OAM_DMA_STATUS_EN exposes o_dma_done and o_dma_idx.
module oam_dma_arbiter
   import oam_dma_pkg::*;
#(
   parameter int unsigned T_PER_M = 4,
   parameter int unsigned DMA_LEN = 160,
   parameter logic [15:0] DMA_DST = 16'hFE00
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [15:0] i_cpu_rd_addr,
   output logic [7:0]  o_cpu_rd_data,
   input  logic        i_cpu_wr_en,
   input  logic [15:0] i_cpu_wr_addr,
   input  logic [7:0]  i_cpu_wr_data,
   output logic [15:0] o_mem_rd_addr,
   input  logic [7:0]  i_mem_rd_data,
   output logic        o_mem_wr_en,
   output logic [15:0] o_mem_wr_addr,
   output logic [7:0]  o_mem_wr_data,
   output logic [6:0]  o_hram_rd_addr,
   input  logic [7:0]  i_hram_rd_data,
   output logic        o_hram_wr_en,
   output logic [6:0]  o_hram_wr_addr,
   output logic [7:0]  o_hram_wr_data,
   output logic        o_dma_active
`ifdef OAM_DMA_STATUS_EN
  ,output logic        o_dma_done,
   output logic [7:0]  o_dma_idx
`endif
);

   logic        wr_hram, wr_reg, wr_main;
   logic        dma_active, eng_wr_en;
   logic [7:0]  dma_src, eng_wr_data;
   logic [15:0] eng_rd_addr, eng_wr_addr;
   rd_sel_t     rd_sel_d, rd_sel_q;

   oam_dma_engine #(
      .T_PER_M (T_PER_M),
      .DMA_LEN (DMA_LEN),
      .DMA_DST (DMA_DST)
   ) u_engine (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_trig        (wr_reg),
      .i_trig_data   (i_cpu_wr_data),
      .i_mem_rd_data (i_mem_rd_data),
      .o_active      (dma_active),
      .o_src         (dma_src),
      .o_rd_addr     (eng_rd_addr),
      .o_wr_en       (eng_wr_en),
      .o_wr_addr     (eng_wr_addr),
      .o_wr_data     (eng_wr_data)
`ifdef OAM_DMA_STATUS_EN
     ,.o_done        (o_dma_done),
      .o_idx         (o_dma_idx)
`endif
   );

   always_comb begin
      wr_hram = i_cpu_wr_en && is_hram(i_cpu_wr_addr);
      wr_reg  = i_cpu_wr_en && (i_cpu_wr_addr == DMA_REG_ADDR);
      wr_main = i_cpu_wr_en && !is_hram(i_cpu_wr_addr) && (i_cpu_wr_addr != DMA_REG_ADDR);

      o_dma_active   = dma_active;
      o_hram_rd_addr = i_cpu_rd_addr[6:0];
      o_hram_wr_en   = wr_hram;
      o_hram_wr_addr = i_cpu_wr_addr[6:0];
      o_hram_wr_data = i_cpu_wr_data;

      // main bus belongs to the engine for the whole active window; CPU main writes are dropped
      if (dma_active) begin
         o_mem_rd_addr = eng_rd_addr;
         o_mem_wr_en   = eng_wr_en;
         o_mem_wr_addr = eng_wr_addr;
         o_mem_wr_data = eng_wr_data;
      end else begin
         o_mem_rd_addr = i_cpu_rd_addr;
         o_mem_wr_en   = wr_main;
         o_mem_wr_addr = i_cpu_wr_addr;
         o_mem_wr_data = i_cpu_wr_data;
      end

      if (is_hram(i_cpu_rd_addr))              rd_sel_d = HRAM;
      else if (i_cpu_rd_addr == DMA_REG_ADDR)  rd_sel_d = REG;
      else if (dma_active)                     rd_sel_d = BLOCKED;
      else                                     rd_sel_d = MAIN;

      unique case (rd_sel_q)
         HRAM:    o_cpu_rd_data = i_hram_rd_data;
         REG:     o_cpu_rd_data = dma_src;
         BLOCKED: o_cpu_rd_data = 8'hFF;
         default: o_cpu_rd_data = i_mem_rd_data;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) rd_sel_q <= MAIN;
      else       rd_sel_q <= rd_sel_d;
   end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed bench for oam_dma_arbiter: idle routing vector table plus DMA copy, restart and reset sequences.
module tb_oam_dma_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] cpu_ra, cpu_wa, mem_ra, mem_wa;
   logic [7:0]  cpu_rd, cpu_wd, mem_rd, mem_wd, hram_rd, hram_wd;
   logic        cpu_we, mem_we, hram_we, dma_active;
   logic [6:0]  hram_ra, hram_wa;
`ifdef OAM_DMA_STATUS_EN
   logic        dma_done;
   logic [7:0]  dma_idx;
`endif

   always #5 clk = ~clk;

   oam_dma_arbiter #(
      .T_PER_M (4),
      .DMA_LEN (160),
      .DMA_DST (16'hFE00)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_cpu_rd_addr  (cpu_ra),
      .o_cpu_rd_data  (cpu_rd),
      .i_cpu_wr_en    (cpu_we),
      .i_cpu_wr_addr  (cpu_wa),
      .i_cpu_wr_data  (cpu_wd),
      .o_mem_rd_addr  (mem_ra),
      .i_mem_rd_data  (mem_rd),
      .o_mem_wr_en    (mem_we),
      .o_mem_wr_addr  (mem_wa),
      .o_mem_wr_data  (mem_wd),
      .o_hram_rd_addr (hram_ra),
      .i_hram_rd_data (hram_rd),
      .o_hram_wr_en   (hram_we),
      .o_hram_wr_addr (hram_wa),
      .o_hram_wr_data (hram_wd),
      .o_dma_active   (dma_active)
`ifdef OAM_DMA_STATUS_EN
     ,.o_dma_done     (dma_done),
      .o_dma_idx      (dma_idx)
`endif
   );

   // Memory image contents used for preload and for expected DMA data
   function automatic logic [7:0] pre(input logic [15:0] a);
      if (a[15:8] == 8'hC0)      return a[7:0];
      else if (a[15:8] == 8'hC1) return ~a[7:0];
      else if (a[15:8] == 8'hD0) return a[7:0] + 8'h40;
      else                       return a[15:8] ^ a[7:0];
   endfunction

   logic [7:0] mem [65536];
   logic [7:0] hram [128];
   logic       do_preload = 1'b0;

   always @(posedge clk) begin
      if (do_preload) begin
         for (int i = 0; i < 65536; i++) mem[i] <= pre(16'(i));
      end else begin
         mem_rd <= mem[mem_ra];
         if (mem_we) mem[mem_wa] <= mem_wd;
      end
      hram_rd <= hram[hram_ra];
      if (hram_we) hram[hram_wa] <= hram_wd;
   end

   int         cyc_cnt = 0;
   int         act_cnt = 0;
   logic [15:0] lg_a [$];
   logic [7:0]  lg_d [$];
   int          lg_c [$];

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   always @(negedge clk) begin
      if (dma_active) act_cnt <= act_cnt + 1;
      if (mem_we && mem_wa >= 16'hFE00 && mem_wa <= 16'hFE9F) begin
         lg_a.push_back(mem_wa);
         lg_d.push_back(mem_wd);
         lg_c.push_back(cyc_cnt);
      end
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic trig(input logic [7:0] s, output int t0);
      cpu_we = 1'b1; cpu_wa = 16'hFF46; cpu_wd = s;
      step();
      cpu_we = 1'b0;
      t0 = cyc_cnt;
   endtask

   task automatic wait_idle();
      int i;
      for (i = 0; i < 2000; i++) begin
         if (!dma_active) break;
         step();
      end
      chk("idle_timeout", {63'd0, dma_active}, 64'd0);
   endtask

   task automatic wait_wr(input logic [15:0] a);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if (mem_we && mem_wa == a) begin
            found = 1'b1;
            break;
         end
         step();
      end
      chk("wait_wr", {63'd0, found}, 64'd1);
   endtask

   task automatic chk_log(input string nm, input int b, input int n, input logic [15:0] sbase, input int cbase);
      for (int i = 0; i < n; i++) begin
         if (b + i >= lg_a.size()) begin
            chk({nm, "_missing"}, 64'(b + i), 64'(lg_a.size()));
            break;
         end
         chk(nm, {24'd0, lg_a[b+i], lg_d[b+i], 16'(lg_c[b+i] - cbase)},
                 {24'd0, 16'hFE00 + 16'(i), pre(sbase + 16'(i)), 16'(4*i + 7)});
      end
   endtask

   typedef struct {
      logic        we;
      logic [15:0] wa;
      logic [7:0]  wd;
      logic [15:0] ra;
      logic        e_mwe;
      logic        e_hwe;
      logic [7:0]  e_rd;
   } vec_t;

   vec_t vt [10];
   int   t0, b, a0;

   initial begin
      vt[0] = '{1'b0, 16'h0000, 8'h00, 16'hFF46, 1'b0, 1'b0, 8'hFF};
      vt[1] = '{1'b1, 16'hC000, 8'h5A, 16'h0150, 1'b1, 1'b0, 8'h51};
      vt[2] = '{1'b0, 16'h0000, 8'h00, 16'hC000, 1'b0, 1'b0, 8'h5A};
      vt[3] = '{1'b1, 16'hFF90, 8'h33, 16'hFF46, 1'b0, 1'b1, 8'hFF};
      vt[4] = '{1'b0, 16'h0000, 8'h00, 16'hFF90, 1'b0, 1'b0, 8'h33};
      vt[5] = '{1'b1, 16'hFFFF, 8'h12, 16'hFF7F, 1'b1, 1'b0, 8'h80};
      vt[6] = '{1'b1, 16'hFF80, 8'h44, 16'hFFFF, 1'b0, 1'b1, 8'h12};
      vt[7] = '{1'b0, 16'h0000, 8'h00, 16'hFF80, 1'b0, 1'b0, 8'h44};
      vt[8] = '{1'b1, 16'hFFFE, 8'h9A, 16'hFF80, 1'b0, 1'b1, 8'h44};
      vt[9] = '{1'b0, 16'h0000, 8'h00, 16'hFFFE, 1'b0, 1'b0, 8'h9A};

      rst = 1'b1; cpu_we = 1'b0; cpu_wa = '0; cpu_wd = '0; cpu_ra = '0;
      do_preload = 1'b1;
      step();
      do_preload = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      step();
      chk("rst_active", {63'd0, dma_active}, 64'd0);
      chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
      chk("rst_hram_we", {63'd0, hram_we}, 64'd0);

      // Idle routing table
      foreach (vt[i]) begin
         cpu_we = vt[i].we; cpu_wa = vt[i].wa; cpu_wd = vt[i].wd; cpu_ra = vt[i].ra;
         #1;
         chk($sformatf("v%0d_mem_we", i), {63'd0, mem_we}, {63'd0, vt[i].e_mwe});
         chk($sformatf("v%0d_hram_we", i), {63'd0, hram_we}, {63'd0, vt[i].e_hwe});
         if (vt[i].e_mwe) chk($sformatf("v%0d_mem_wr", i), {40'd0, mem_wa, mem_wd}, {40'd0, vt[i].wa, vt[i].wd});
         if (vt[i].e_hwe) chk($sformatf("v%0d_hram_wr", i), {49'd0, hram_wa, hram_wd}, {49'd0, vt[i].wa[6:0], vt[i].wd});
         step();
         cpu_we = 1'b0;
         chk($sformatf("v%0d_rd", i), {56'd0, cpu_rd}, {56'd0, vt[i].e_rd});
      end

      // Plain copy from C000 with CPU traffic during the transfer
      cpu_ra = 16'h0000;
      do_preload = 1'b1;
      step();
      do_preload = 1'b0;
      b = lg_a.size(); a0 = act_cnt;
      trig(8'hC0, t0);
      chk("start_active", {63'd0, dma_active}, 64'd1);
      chk("start_no_wr", {63'd0, mem_we}, 64'd0);
      repeat (10) step();
      cpu_ra = 16'h0150; cpu_we = 1'b1; cpu_wa = 16'hC123; cpu_wd = 8'hEE;
      #1;
      chk("blk_wr", {63'd0, mem_we}, 64'd0);
      step();
      chk("blk_rd", {56'd0, cpu_rd}, 64'hFF);
      cpu_wa = 16'hFF90; cpu_wd = 8'h66; cpu_ra = 16'hFF46;
      #1;
      chk("dma_hram_we", {63'd0, hram_we}, 64'd1);
      step();
      cpu_we = 1'b0; cpu_ra = 16'hFF90;
      chk("dma_reg_rd", {56'd0, cpu_rd}, 64'hC0);
      step();
      chk("dma_hram_rd", {56'd0, cpu_rd}, 64'h66);
      cpu_ra = 16'h0000;
      wait_idle();
      chk("c0_active_len", 64'(act_cnt - a0), 64'd644);
      chk("c0_wr_count", 64'(lg_a.size() - b), 64'd160);
      chk_log("c0_wr", b, 160, 16'hC000, t0);
      chk("blk_mem_kept", {56'd0, mem[16'hC123]}, {56'd0, pre(16'hC123)});

      // Echo-mirror source E1 -> C100
      b = lg_a.size(); a0 = act_cnt;
      trig(8'hE1, t0);
      wait_idle();
      chk("e1_active_len", 64'(act_cnt - a0), 64'd644);
      chk_log("e1_wr", b, 160, 16'hC100, t0);

      // Restart with D0 on the cycle FE31 is written
      b = lg_a.size(); a0 = act_cnt;
      trig(8'hC0, t0);
      wait_wr(16'hFE31);
      cpu_we = 1'b1; cpu_wa = 16'hFF46; cpu_wd = 8'hD0;
      step();
      cpu_we = 1'b0;
      wait_idle();
      chk("rs_active_len", 64'(act_cnt - a0), 64'd848);
      chk("rs_wr_count", 64'(lg_a.size() - b), 64'd210);
      chk_log("rs_first", b, 50, 16'hC000, t0);
      chk_log("rs_second", b + 50, 160, 16'hD000, t0 + 204);

      // FF46 write coinciding with the final DMA write
      b = lg_a.size(); a0 = act_cnt;
      trig(8'hC0, t0);
      wait_wr(16'hFE9F);
      cpu_we = 1'b1; cpu_wa = 16'hFF46; cpu_wd = 8'hD0;
      step();
      cpu_we = 1'b0;
      chk("sim_still_active", {63'd0, dma_active}, 64'd1);
      wait_idle();
      chk("sim_active_len", 64'(act_cnt - a0), 64'd1288);
      chk_log("sim_first", b, 160, 16'hC000, t0);
      chk_log("sim_second", b + 160, 160, 16'hD000, t0 + 644);

      // Reset while idx=20 is in flight
      b = lg_a.size();
      trig(8'hC0, t0);
      wait_wr(16'hFE13);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0; cpu_ra = 16'hFF46;
      chk("rst_mid_active", {63'd0, dma_active}, 64'd0);
      step();
      chk("rst_mid_src", {56'd0, cpu_rd}, 64'hFF);
      repeat (700) step();
      chk("rst_mid_wr_count", 64'(lg_a.size() - b), 64'd20);
      chk_log("rst_mid_wr", b, 20, 16'hC000, t0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
